// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns the EX/MEM address, store data and
// control into a word-aligned, byte-strobed request on a ready-handshaked
// data-memory port, extends returned load data, and holds the pipeline
// frozen until the access completes or is abandoned on timeout.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no access in flight; stall asserted combinationally when one is needed
// REQ   | request outstanding, fields frozen, waiting for Dmem_ready or timeout
// DONE  | access finished; pipeline advances this cycle, bus_err visible here
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_Mem,
    input  logic        rst_n_Mem,
    input  logic        valid_in_Mem,
    input  logic [31:0] ALU_in_Mem,
    input  logic [31:0] Rs2_data_in_Mem,
    input  logic        MemRead_in_Mem,
    input  logic        MemRW_in_Mem,
    input  logic [2:0]  funct3_in_Mem,
    input  logic [31:0] Dmem_rdata,
    input  logic        Dmem_ready,
    output logic        Dmem_req,
    output logic        Dmem_we,
    output logic [31:0] Dmem_addr,
    output logic [31:0] Dmem_wdata,
    output logic [3:0]  Dmem_wstrb,
    output logic [31:0] Dmem_data_out_Mem,
    output logic        stall_Mem,
    output logic        misalign_Mem,
    output logic        bus_err_Mem
);

    // The counter only ever needs to hold TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   dout_q;
    logic          bus_err_q;

    logic          mem_op;
    logic          is_store;
    logic          is_load;
    logic          aligned;
    logic          access_needed;
    logic [3:0]    strb_d;
    logic [31:0]   wdata_d;
    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [31:0]   load_ext_d;

    // A store takes priority when both read and write are flagged.
    assign mem_op   = MemRead_in_Mem | MemRW_in_Mem;
    assign is_store = MemRW_in_Mem;
    assign is_load  = MemRead_in_Mem & ~MemRW_in_Mem;

    // Alignment check from the access size in funct3[1:0].
    always_comb begin
        aligned = 1'b1;
        case (funct3_in_Mem[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~ALU_in_Mem[0];
            default: aligned = (ALU_in_Mem[1:0] == 2'b00);
        endcase
    end

    assign access_needed = valid_in_Mem & mem_op & aligned;
    assign misalign_Mem  = valid_in_Mem & mem_op & ~aligned;

    // Store byte strobes and lane-replicated write data.
    always_comb begin
        strb_d  = 4'b1111;
        wdata_d = Rs2_data_in_Mem;
        case (funct3_in_Mem[1:0])
            2'b00: begin
                strb_d  = 4'b0001 << ALU_in_Mem[1:0];
                wdata_d = {4{Rs2_data_in_Mem[7:0]}};
            end
            2'b01: begin
                strb_d  = 4'b0011 << {ALU_in_Mem[1], 1'b0};
                wdata_d = {2{Rs2_data_in_Mem[15:0]}};
            end
            default: begin
                strb_d  = 4'b1111;
                wdata_d = Rs2_data_in_Mem;
            end
        endcase
    end

    // Lane selection and sign/zero extension of the returned read word.
    always_comb begin
        byte_lane = Dmem_rdata[7:0];
        case (ALU_in_Mem[1:0])
            2'b00: byte_lane = Dmem_rdata[7:0];
            2'b01: byte_lane = Dmem_rdata[15:8];
            2'b10: byte_lane = Dmem_rdata[23:16];
            2'b11: byte_lane = Dmem_rdata[31:24];
            default: byte_lane = Dmem_rdata[7:0];
        endcase
        half_lane = ALU_in_Mem[1] ? Dmem_rdata[31:16] : Dmem_rdata[15:0];
        case (funct3_in_Mem)
            3'b000:  load_ext_d = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_ext_d = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_ext_d = {24'd0, byte_lane};
            3'b101:  load_ext_d = {16'd0, half_lane};
            default: load_ext_d = Dmem_rdata;
        endcase
    end

    // Stall is a function of state; in IDLE it reacts to the incoming slot.
    always_comb begin
        stall_Mem = 1'b0;
        case (state_q)
            IDLE:    stall_Mem = access_needed;
            REQ:     stall_Mem = 1'b1;
            DONE:    stall_Mem = 1'b0;
            default: stall_Mem = 1'b0;
        endcase
    end

    // Access sequencer with registered request, result and error outputs.
    // EX/MEM inputs are held stable by the stall, so REQ reads them directly.
    always_ff @(posedge clk_Mem or negedge rst_n_Mem) begin
        if (!rst_n_Mem) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            dout_q    <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bus_err_q <= 1'b0;
                    if (access_needed) begin
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {ALU_in_Mem[31:2], 2'b00};
                        wdata_q <= wdata_d;
                        wstrb_q <= is_store ? strb_d : 4'd0;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (Dmem_ready) begin
                        if (is_load) begin
                            dout_q <= load_ext_d;
                        end
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        wstrb_q <= 4'd0;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        if (is_load) begin
                            dout_q <= 32'd0;
                        end
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        wstrb_q   <= 4'd0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    bus_err_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    req_q     <= 1'b0;
                    we_q      <= 1'b0;
                    wstrb_q   <= 4'd0;
                    bus_err_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign Dmem_req          = req_q;
    assign Dmem_we           = we_q;
    assign Dmem_addr         = addr_q;
    assign Dmem_wdata        = wdata_q;
    assign Dmem_wstrb        = wstrb_q;
    assign Dmem_data_out_Mem = dout_q;
    assign bus_err_Mem       = bus_err_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns the EX/MEM address, store data and control into a word-aligned request with byte strobes on a ready-handshaked data-memory port. It sign- or zero-extends load data and freezes the pipeline (`stall_Mem`) until the access completes or times out. Its load result drives the MEM/WB memory-data input; `stall_Mem` is ORed into the upstream enables and inverted into the MEM/WB enable.

## Interface
- `TIMEOUT`, default 16: number of cycles `Dmem_req` may wait for `Dmem_ready` before the access is abandoned (≥1).
- `clk_Mem` in 1: single clock; all state updates on the rising edge.
- `rst_n_Mem` in 1: reset, asynchronous, active-low.
- `valid_in_Mem` in 1: EX/MEM slot holds a real instruction.
- `ALU_in_Mem` in 32: effective byte address.
- `Rs2_data_in_Mem` in 32: store data.
- `MemRead_in_Mem` in 1: load.
- `MemRW_in_Mem` in 1: store. If both are set, the store wins.
- `funct3_in_Mem` in 3: access size and extension.
- `Dmem_rdata` in 32: memory read word, valid while `Dmem_ready`=1.
- `Dmem_ready` in 1: memory accepts or completes the current request.
- `Dmem_req` out 1: request valid (registered).
- `Dmem_we` out 1: write request (registered).
- `Dmem_addr` out 32: `{ALU_in_Mem[31:2],2'b00}` (registered).
- `Dmem_wdata` out 32: lane-replicated store data (registered).
- `Dmem_wstrb` out 4: byte-write strobes; 0 on loads (registered).
- `Dmem_data_out_Mem` out 32: extended load result (registered).
- `stall_Mem` out 1: freeze PC, IF/ID, ID/EX, EX/MEM; deassert the MEM/WB enable.
- `misalign_Mem` out 1: current access is misaligned (combinational).
- `bus_err_Mem` out 1: access timed out (registered, one cycle).

## Operation
- An access is needed when `valid_in_Mem` is set, `MemRead_in_Mem | MemRW_in_Mem` is set, and the address is aligned.
- Alignment rules:
  - Halfword (funct3[1:0]=01) needs addr[0]=0.
  - Word (10 or 11) needs addr[1:0]=0.
  - Byte accesses are always aligned.
- A misaligned access sets `misalign_Mem`=1, issues no request, does not stall, and leaves `Dmem_data_out_Mem` unchanged.
- Load extension:
  - funct3 000 = lb (sign-extend byte).
  - 001 = lh (sign-extend half).
  - 010 / 011 = lw.
  - 100 = lbu, 101 = lhu (zero-extend).
  - 110 / 111 = lw.
- Byte and half lanes are selected by addr[1:0] / addr[1].
- Store strobes and data:
  - sb: strobe `4'b0001<<addr[1:0]`, data `{4{rs2[7:0]}}`.
  - sh: strobe `4'b0011<<{addr[1],1'b0}`, data `{2{rs2[15:0]}}`.
  - Otherwise: strobe `4'b1111`, data `rs2`.
- FSM states IDLE, REQ, DONE:
  - IDLE:
    - `stall_Mem` = access-needed.
    - When access-needed, register the `Dmem_*` outputs with `Dmem_req`=1, clear the counter, and go to REQ.
  - REQ:
    - `stall_Mem`=1. `Dmem_req` and all request fields are held constant.
    - The counter increments each cycle.
    - On `Dmem_ready`=1: capture extended `Dmem_rdata` into `Dmem_data_out_Mem` (loads only), drop `Dmem_req`/`Dmem_we`/`Dmem_wstrb`, and go to DONE.
    - Else, when the counter reaches `TIMEOUT`-1: drop the request, set `Dmem_data_out_Mem` to 0 (loads), set `bus_err_Mem`, and go to DONE.
  - DONE:
    - `stall_Mem`=0, so the pipeline and MEM/WB advance this cycle.
    - `bus_err_Mem` is visible only in this cycle.
    - Next state is IDLE.
- EX/MEM inputs are guaranteed stable while `stall_Mem`=1. The block does not re-sample them in REQ.

## Timing
- Reset (async, `rst_n_Mem`=0):
  - State goes to IDLE and the counter to 0.
  - `Dmem_req`, `Dmem_we`, `Dmem_addr`, `Dmem_wdata`, `Dmem_wstrb`, `Dmem_data_out_Mem` and `bus_err_Mem` all go to 0.
  - `stall_Mem` and `misalign_Mem` follow from IDLE and the inputs.
  - Reset during REQ drops `Dmem_req` immediately, without waiting for the clock.
- Minimum access latency is 3 cycles.
  - Cycle N: IDLE, stall=1.
  - Cycle N+1: REQ with `Dmem_req`=1; `Dmem_ready`=1 is sampled at the end of N+1.
  - Cycle N+2: DONE, stall=0, data valid.
- Each additional wait cycle of `Dmem_ready` adds one cycle of stall.
- Timeout: DONE is reached `TIMEOUT`+1 cycles after N.
- Back-to-back accesses: DONE → IDLE, so a following memory instruction starts its IDLE cycle right after DONE. The gap between requests is one idle cycle.
- `Dmem_ready` is ignored outside REQ.

## Test plan
- Load, aligned byte: lb at addr 0x103 with `Dmem_rdata`=0x80AB_CDEF and ready in the first REQ cycle → `Dmem_addr`=0x100, `Dmem_wstrb`=0, `Dmem_data_out_Mem`=0xFFFF_FF80, stall high for exactly 2 cycles.
- Store, halfword: sh at addr 0x206, rs2=0x1234_5678 → `Dmem_we`=1, `Dmem_wstrb`=4'b1100, `Dmem_wdata`=0x5678_5678, `Dmem_addr`=0x204.
- Misaligned: lw at addr 0x102 → `misalign_Mem`=1, `Dmem_req` never asserts, `stall_Mem`=0.
- Wait states: lhu at addr 0x302 with ready delayed 3 cycles and `Dmem_rdata`=0xBEEF_0000 → stall for 5 cycles, result 0x0000_BEEF, request fields constant throughout REQ.
- Timeout then reset: `TIMEOUT`=4 with ready never asserted → `bus_err_Mem` pulses for one cycle in DONE and the result is 0. On a second access, assert `rst_n_Mem`=0 mid-REQ → `Dmem_req`=0 asynchronously and the FSM is back in IDLE.
